// File: rtl/vga_agc.sv
// vga_agc: windowed peak detector driving a VGA attenuator through a pulse/busy SPI-writer handshake.
// Optional build macro VGA_AGC_HYST_EN: a step needs two consecutive windows with the same verdict.
module vga_agc #(
  parameter int WIN_LOG2  = 10,
  parameter int HI_THRESH = 24576,
  parameter int LO_THRESH = 6144,
  parameter int STEP      = 1
) (
  input  logic        i_clk125,
  input  logic        i_rst,
  input  logic        i_adc_valid,
  input  logic [15:0] i_adc_data,
  input  logic        i_agc_en,
  input  logic        i_sw_wr,
  input  logic [6:0]  i_sw_val,
  input  logic        i_spi_busy,
  output logic        o_update_gain_ctrl,
  output logic [6:0]  o_gain_ctrl_val,
  output logic [5:0]  o_atten,
  output logic        o_pending,
  output logic [1:0]  o_dbg_state
);

  // Handshake: o_update_gain_ctrl is a one-cycle strobe issued only while the writer is idle
  // (i_spi_busy=0); the writer acknowledges by raising i_spi_busy and finishes by dropping it.
  // o_gain_ctrl_val is valid with the strobe and stays stable until the next strobe.

  localparam logic [15:0] HI_LVL  = 16'(HI_THRESH);
  localparam logic [15:0] LO_LVL  = 16'(LO_THRESH);
  localparam logic [6:0]  STEP_W  = 7'(STEP);
  localparam logic [6:0]  ATT_MAX = 7'd32;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [WIN_LOG2-1:0] r_win_cnt;
  logic [15:0]         r_peak;
  logic [5:0]          r_atten;
  logic                r_pd;
  logic                r_pending;
  logic [6:0]          r_gain_val;
  logic [1:0]          r_wait_cnt;

  logic [15:0] w_neg;
  logic [15:0] w_mag;
  logic [15:0] w_peak_upd;
  logic        w_win_open;
  logic        w_sample;
  logic        w_wrap;
  logic        w_hi;
  logic        w_lo;
  logic        w_decide;
  logic        w_step_up;
  logic        w_step_dn;
  logic [6:0]  w_sum;
  logic [5:0]  w_att_up;
  logic [5:0]  w_att_dn;
  logic [5:0]  w_sw_att;
  logic [5:0]  w_atten_next;
  logic        w_pd_next;
  logic        w_issue;
  logic        w_retry;
  logic        w_restart;
  logic        w_set_pending;

  // -32768 has no positive twin in 16 bits, so it saturates to 32767.
  assign w_neg = ~i_adc_data + 16'd1;
  assign w_mag = !i_adc_data[15]          ? i_adc_data :
                 (i_adc_data == 16'h8000) ? 16'h7FFF   : w_neg;

  assign w_win_open = (r_state == S_IDLE) || (r_state == S_ISSUE);
  assign w_sample   = i_adc_valid && w_win_open;
  assign w_wrap     = w_sample && (r_win_cnt == {WIN_LOG2{1'b1}});
  assign w_peak_upd = (w_mag > r_peak) ? w_mag : r_peak;
  assign w_hi       = w_peak_upd > HI_LVL;
  assign w_lo       = w_peak_upd < LO_LVL;
  assign w_decide   = w_wrap && i_agc_en && !i_sw_wr;

  assign w_sum    = {1'b0, r_atten} + STEP_W;
  assign w_att_up = (w_sum > ATT_MAX) ? ATT_MAX[5:0] : w_sum[5:0];
  assign w_att_dn = ({1'b0, r_atten} < STEP_W) ? 6'd0 : 6'({1'b0, r_atten} - STEP_W);
  assign w_sw_att = ({1'b0, i_sw_val[5:0]} > ATT_MAX) ? ATT_MAX[5:0] : i_sw_val[5:0];

`ifdef VGA_AGC_HYST_EN
  typedef enum logic [1:0] {
    H_NONE = 2'd0,
    H_HIGH = 2'd1,
    H_LOW  = 2'd2
  } hist_t;

  hist_t r_hist;

  assign w_step_up = w_decide && w_hi && (r_hist == H_HIGH);
  assign w_step_dn = w_decide && !w_hi && w_lo && (r_hist == H_LOW);

  // History holds the last verdict; an opposite verdict starts a fresh pair, a step consumes it.
  always_ff @(posedge i_clk125 or posedge i_rst) begin
    if (i_rst) begin
      r_hist <= H_NONE;
    end else if (i_sw_wr) begin
      r_hist <= H_NONE;
    end else if (w_decide) begin
      if (w_step_up || w_step_dn) r_hist <= H_NONE;
      else if (w_hi)              r_hist <= H_HIGH;
      else if (w_lo)              r_hist <= H_LOW;
      else                        r_hist <= H_NONE;
    end
  end
`else
  assign w_step_up = w_decide && w_hi;
  assign w_step_dn = w_decide && !w_hi && w_lo;
`endif

  // Software write outranks a coincident window decision.
  always_comb begin
    w_atten_next = r_atten;
    w_pd_next    = r_pd;
    if (i_sw_wr) begin
      w_atten_next = w_sw_att;
      w_pd_next    = i_sw_val[6];
    end else if (w_step_up) begin
      w_atten_next = w_att_up;
    end else if (w_step_dn) begin
      w_atten_next = w_att_dn;
    end
  end

  always_ff @(posedge i_clk125 or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (r_pending && !i_spi_busy) w_state_next = S_ISSUE;
      S_ISSUE:     w_state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (i_spi_busy)              w_state_next = S_WAIT_DONE;
        else if (r_wait_cnt == 2'd3) w_state_next = S_IDLE;
      end
      S_WAIT_DONE: if (!i_spi_busy) w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_issue   = (r_state == S_ISSUE);
    w_retry   = (r_state == S_WAIT_BUSY) && !i_spi_busy && (r_wait_cnt == 2'd3);
    w_restart = i_sw_wr || ((r_state == S_WAIT_DONE) && !i_spi_busy);
  end

  assign w_set_pending = i_sw_wr || (w_atten_next != r_atten) || w_retry;

  always_ff @(posedge i_clk125 or posedge i_rst) begin
    if (i_rst) begin
      r_atten    <= 6'd32;
      r_pd       <= 1'b0;
      r_pending  <= 1'b1;
      r_gain_val <= 7'h20;
      r_wait_cnt <= 2'd0;
      r_win_cnt  <= '0;
      r_peak     <= 16'd0;
    end else begin
      r_atten    <= w_atten_next;
      r_pd       <= w_pd_next;
      r_pending  <= w_set_pending || (r_pending && !w_issue);
      if (w_issue) r_gain_val <= {r_pd, r_atten};
      r_wait_cnt <= (r_state == S_WAIT_BUSY) ? r_wait_cnt + 2'd1 : 2'd0;
      if (w_restart) begin
        r_win_cnt <= '0;
        r_peak    <= 16'd0;
      end else if (w_sample) begin
        r_win_cnt <= r_win_cnt + WIN_LOG2'(1);
        r_peak    <= w_wrap ? 16'd0 : w_peak_upd;
      end
    end
  end

  assign o_update_gain_ctrl = w_issue;
  assign o_gain_ctrl_val    = w_issue ? {r_pd, r_atten} : r_gain_val;
  assign o_atten            = r_atten;
  assign o_pending          = r_pending;
  assign o_dbg_state        = r_state;

endmodule
